// File: rtl/bsg_downstream_sched.sv
// ---------------------------------------------------------------------------
// bsg_downstream_sched
//
// Core-domain sequencing controller for the downstream link channels. It
// drains one CH_W-bit word from each channel FIFO strictly in channel order,
// assembles the words into one core word (channel 0 in the LSBs) and presents
// it to the core with a valid/yumi handshake. Every 2**LG_TOKEN_BATCH words
// dequeued from a channel, a one-cycle token pulse is returned upstream for
// that channel.
//
// Ports:
//   clk           core clock, all state on its rising edge
//   rst_n         asynchronous active-low reset
//   enable_i      when low, no new channel dequeues are started
//   ch_valid_i    per-channel FIFO not empty
//   ch_data_i     per-channel FIFO head data, channel c at [c*CH_W +: CH_W]
//   ch_yumi_o     per-channel dequeue strobe (combinational)
//   core_data_o   assembled core word (registered)
//   core_valid_o  assembled word available (registered)
//   core_yumi_i   core accepts the word
//   token_o       per-channel one-cycle token pulse (registered)
//   words_o       count of delivered core words, wraps
//   busy_o        FSM not idle
// ---------------------------------------------------------------------------
module bsg_downstream_sched #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned CH_W           = 16,
  parameter int unsigned LG_TOKEN_BATCH = 2,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable_i,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  input  logic [NUM_CH*CH_W-1:0]   ch_data_i,
  output logic [NUM_CH-1:0]        ch_yumi_o,
  output logic [NUM_CH*CH_W-1:0]   core_data_o,
  output logic                     core_valid_o,
  input  logic                     core_yumi_i,
  output logic [NUM_CH-1:0]        token_o,
  output logic [CNT_W-1:0]         words_o,
  output logic                     busy_o
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_e;

  state_e                                 state_q, state_d;
  logic [IDX_W-1:0]                       idx_q, idx_d;
  logic [NUM_CH-1:0][CH_W-1:0]            slot_q, slot_d;
  logic [NUM_CH-1:0][LG_TOKEN_BATCH-1:0]  tcnt_q, tcnt_d;
  logic [NUM_CH-1:0]                      token_q, token_d;
  logic                                   core_valid_q, core_valid_d;
  logic [NUM_CH*CH_W-1:0]                 core_data_q, core_data_d;
  logic [CNT_W-1:0]                       words_q, words_d;

  logic [NUM_CH-1:0]                      yumi;
  logic                                   last_idx;

  assign last_idx = (idx_q == IDX_W'(NUM_CH - 1));

  // Only the channel currently pointed to by idx may be dequeued.
  always_comb begin
    yumi = '0;
    if (state_q == COLLECT) begin
      yumi[idx_q] = ch_valid_i[idx_q] & enable_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    slot_d       = slot_q;
    core_valid_d = core_valid_q;
    core_data_d  = core_data_q;
    words_d      = words_q;

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = COLLECT;
          idx_d   = '0;
        end
      end

      COLLECT: begin
        if (yumi[idx_q]) begin
          slot_d[idx_q] = ch_data_i[int'(idx_q)*CH_W +: CH_W];
          if (last_idx) begin
            // Load the output word from the updated slots so the final
            // channel's data is included on the same edge.
            state_d      = PRESENT;
            idx_d        = '0;
            core_valid_d = 1'b1;
            core_data_d  = slot_d;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (!enable_i && (idx_q == '0)) begin
          // Nothing collected yet, so it is safe to go idle; a partial word
          // instead stalls here until enable returns.
          state_d = IDLE;
        end
      end

      PRESENT: begin
        if (core_yumi_i) begin
          core_valid_d = 1'b0;
          words_d      = words_q + CNT_W'(1);
          idx_d        = '0;
          state_d      = enable_i ? COLLECT : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Token counters advance on every dequeue; the pulse fires on the edge
  // after the dequeue that wraps the counter.
  always_comb begin
    tcnt_d  = tcnt_q;
    token_d = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      token_d[c] = yumi[c] & (&tcnt_q[c]);
      if (yumi[c]) begin
        tcnt_d[c] = tcnt_q[c] + LG_TOKEN_BATCH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      slot_q       <= '0;
      tcnt_q       <= '0;
      token_q      <= '0;
      core_valid_q <= 1'b0;
      core_data_q  <= '0;
      words_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      slot_q       <= slot_d;
      tcnt_q       <= tcnt_d;
      token_q      <= token_d;
      core_valid_q <= core_valid_d;
      core_data_q  <= core_data_d;
      words_q      <= words_d;
    end
  end

  assign ch_yumi_o    = yumi;
  assign core_data_o  = core_data_q;
  assign core_valid_o = core_valid_q;
  assign token_o      = token_q;
  assign words_o      = words_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: doc/bsg_downstream_sched.md
Name: bsg_downstream_sched

Overview:
- Sequencing controller for the downstream link channels.
- Drains one 16-bit word from each channel's async-FIFO read side, strictly in channel order.
- Assembles the words into one core word, presents it to the core with a valid/yumi handshake, and returns flow-control tokens upstream after every TOKEN_BATCH words dequeued per channel.
- Sits in the core clock domain, between the per-channel downstream FIFOs and the core interface.

Parameters:
- NUM_CH, 2: number of downstream channels combined into one core word.
- CH_W, 16: width of each channel word.
- LG_TOKEN_BATCH, 2: log2 of words dequeued per channel per returned token (batch = 4).
- CNT_W, 16: width of the delivered-word status counter.

Ports:
- clk  in  1  core-side clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable_i  in  1  when low, no new channel dequeues are started.
- ch_valid_i  in  NUM_CH  per-channel FIFO read side not empty.
- ch_data_i  in  NUM_CH*CH_W  per-channel FIFO head data; channel c at bits [c*CH_W +: CH_W].
- ch_yumi_o  out  NUM_CH  dequeue strobe to channel FIFO c.
- core_data_o  out  NUM_CH*CH_W  assembled word; channel 0 in the LSBs.
- core_valid_o  out  1  assembled word available.
- core_yumi_i  in  1  core accepts the word; legal only while core_valid_o=1.
- token_o  out  NUM_CH  one-cycle token pulse per channel to the upstream return path.
- words_o  out  CNT_W  count of core words delivered; wraps.
- busy_o  out  1  high when the FSM is not IDLE.

Behaviour:
Reset (asynchronous, rst_n=0):
- state=IDLE, idx=0, slot registers=0, token counters=0.
- ch_yumi_o=0, core_valid_o=0, core_data_o=0, token_o=0, words_o=0, busy_o=0.
- Reset asserted mid-operation discards any partially collected word; no token is emitted for it.

FSM states: IDLE, COLLECT, PRESENT.
- IDLE → COLLECT: when enable_i=1, on the next edge; idx=0.
- COLLECT:
  - ch_yumi_o[idx] = ch_valid_i[idx] & enable_i, combinationally.
  - Only one channel is dequeued per cycle; the other yumi bits are 0.
  - On a dequeue: slot[idx] ← ch_data_i[idx]; idx ← idx+1.
  - If idx was NUM_CH-1, go to PRESENT instead.
  - If ch_valid_i[idx]=0, stall with idx unchanged. Channels are never skipped and order is never changed.
  - If enable_i=0 with idx=0, go to IDLE.
  - If enable_i=0 with idx>0, hold (stall) until enable_i returns. A partial word is never dropped.
- PRESENT:
  - core_valid_o=1 and core_data_o=concatenated slots, both registered and stable until accepted.
  - On core_yumi_i=1: core_valid_o←0 and words_o←words_o+1 (mod 2^CNT_W). Next state is COLLECT if enable_i=1, else IDLE.
  - No channel dequeue occurs in PRESENT, including the yumi cycle. This gives a 1-cycle bubble.
  - enable_i=0 does not retract core_valid_o.

Latency:
- With all channels valid, first dequeue is in cycle 0 and core_valid_o is high in cycle NUM_CH.
- Steady-state throughput, with yumi asserted immediately: one core word per NUM_CH+1 cycles.

Tokens:
- Each channel has a counter tcnt[c] of width LG_TOKEN_BATCH. It increments on every ch_yumi_o[c] and wraps naturally.
- token_o[c] is registered: it pulses high for exactly one cycle, on the edge following the dequeue that wraps tcnt[c] from all-ones to 0.
- Token pulses are independent of core_yumi_i.
- Multiple channels may pulse in different cycles; they never merge or drop.

Misc:
- busy_o = (state != IDLE).
- core_yumi_i while core_valid_o=0 is ignored (no counter change).

Test Plan:
- Reset then enable_i=1, ch_valid=2'b11, ch0=16'hAAAA, ch1=16'h5555 → yumi[0] in cycle 0, yumi[1] in cycle 1; core_valid_o in cycle 2 with core_data_o=32'h5555AAAA; on yumi, words_o=1.
- ch_valid[1]=0 for 5 cycles after ch0 is dequeued → FSM holds idx=1 with no yumi[0] repeat; once ch_valid[1] rises, data assembles correctly and arrives 5 cycles late.
- Back-to-back delivery of 8 words with core_yumi_i held high → exactly 2 token_o pulses per channel, each 1 cycle wide, after the 4th and 8th dequeue; words_o=8.
- core_yumi_i held low for 10 cycles in PRESENT → core_data_o stable, no ch_yumi_o, no token_o, words_o unchanged.
- enable_i dropped after ch0 is dequeued → ch1 is not dequeued until enable_i rises; enable_i dropped in PRESENT → word still delivered, then state=IDLE and busy_o=0.
- rst_n pulsed low asynchronously mid-COLLECT, between clock edges → all outputs 0 immediately; after release, the next word starts at ch0 and the token count restarts at 0.
